// File: rtl/pico_ctrl_seq_pkg.sv
// Shared definitions for the pico control sequencer: opcodes, FSM states, ALU function codes
// and instruction field positions for the default 15-bit instruction format.
package pico_ctrl_seq_pkg;

  localparam int N   = 8;
  localparam int AW  = 2;
  localparam int PCW = 5;
  localparam int OPW = 3;
  localparam int IW  = OPW + 2 * AW + N;

  localparam int OP_MSB  = IW - 1;
  localparam int OP_LSB  = IW - OPW;
  localparam int RD_MSB  = OP_LSB - 1;
  localparam int RD_LSB  = OP_LSB - AW;
  localparam int RS_MSB  = RD_LSB - 1;
  localparam int RS_LSB  = RD_LSB - AW;
  localparam int IMM_MSB = N - 1;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_ADDI = 3'd2,
    OP_MULI = 3'd3,
    OP_LDSW = 3'd4,
    OP_JMP  = 3'd5,
    OP_BEQ  = 3'd6,
    OP_HLT  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WB,
    S_WAIT_HI,
    S_WAIT_LO,
    S_HALT
  } state_t;

  localparam logic [1:0] ALU_PASS_B = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_MULHI  = 2'b10;
  localparam logic [1:0] ALU_SUB    = 2'b11;

  function automatic logic [IW-1:0] make_instr(input opcode_t op, input logic [AW-1:0] rd,
                                               input logic [AW-1:0] rs, input logic [N-1:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage

// File: rtl/pico_ctrl_seq_pc.sv
// Program counter: synchronous reset, load of a jump target takes priority over increment.
module pico_ctrl_seq_pc #(
  parameter int PCW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc_i,
  input  logic           load_i,
  input  logic [PCW-1:0] target_i,
  output logic [PCW-1:0] pc_o
);

  logic [PCW-1:0] pc_q;
  logic [PCW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = target_i;
    else if (inc_i) pc_d = pc_q + 1'b1;
  end

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pico_ctrl_seq.sv
// Multi-cycle control sequencer: fetches one instruction per pc, decodes it and drives the
// register-file access port, ALU controls and the external switch-load handshake.
module pico_ctrl_seq
  import pico_ctrl_seq_pkg::*;
#(
  parameter int N   = 8,
  parameter int AW  = 2,
  parameter int PCW = 5,
  parameter int OPW = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [OPW+2*AW+N-1:0]     instr,
  input  logic                      sw_ready,
  input  logic                      alu_zero,
  output logic [PCW-1:0]            pc,
  output logic                      rf_write,
  output logic [AW-1:0]             rf_raddr1,
  output logic [AW-1:0]             rf_raddr2,
  output logic [N-1:0]              imm,
  output logic [1:0]                alu_func,
  output logic                      sel_imm,
  output logic                      sel_ext,
  output logic                      halted
);

  localparam int IW = OPW + 2 * AW + N;

  state_t          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  opcode_t         op;
  logic            pc_inc, pc_load;

  assign op        = opcode_t'(ir_q[IW-1 -: OPW]);
  assign rf_raddr1 = ir_q[IW-OPW-1 -: AW];
  assign rf_raddr2 = ir_q[IW-OPW-AW-1 -: AW];
  assign imm       = ir_q[N-1:0];

  pico_ctrl_seq_pc #(.PCW(PCW)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (pc_inc),
    .load_i   (pc_load),
    .target_i (ir_q[PCW-1:0]),
    .pc_o     (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op)
          OP_NOP:                  begin pc_inc = 1'b1; state_d = S_FETCH; end
          OP_ADD, OP_ADDI, OP_MULI: state_d = S_WB;
          OP_LDSW:                 state_d = S_WAIT_HI;
          OP_JMP:                  begin pc_load = 1'b1; state_d = S_FETCH; end
          OP_BEQ: begin
            pc_load = alu_zero;
            pc_inc  = ~alu_zero;
            state_d = S_FETCH;
          end
          OP_HLT:                  state_d = S_HALT;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_WB: begin
        pc_inc  = 1'b1;
        state_d = (op == OP_LDSW) ? S_WAIT_LO : S_FETCH;
      end
      S_WAIT_HI: if (sw_ready)  state_d = S_WB;
      S_WAIT_LO: if (!sw_ready) state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    rf_write = 1'b0;
    alu_func = ALU_PASS_B;
    sel_imm  = 1'b0;
    sel_ext  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_EXEC, S_WB: begin
        unique case (op)
          OP_ADD:  alu_func = ALU_ADD;
          OP_ADDI: begin alu_func = ALU_ADD;   sel_imm = 1'b1; end
          OP_MULI: begin alu_func = ALU_MULHI; sel_imm = 1'b1; end
          default: alu_func = ALU_PASS_B;
        endcase
        if (state_q == S_WB) begin
          rf_write = 1'b1;
          sel_ext  = (op == OP_LDSW);
        end
      end
      S_WAIT_HI, S_WAIT_LO: sel_ext = 1'b1;
      S_HALT:               halted  = 1'b1;
      default:              ;
    endcase
  end

endmodule

// File: tb/tb_pico_ctrl_seq.sv
// Bench for pico_ctrl_seq: an instruction-level model walks the program and predicts every
// cycle's outputs; literal checks on the recorded trace pin the model to hand-computed values.
module tb_pico_ctrl_seq;
  import pico_ctrl_seq_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sw_ready = 1'b0;
  logic            alu_zero = 1'b0;
  logic [IW-1:0]   instr;
  logic [PCW-1:0]  pc;
  logic            rf_write, sel_imm, sel_ext, halted;
  logic [AW-1:0]   rf_raddr1, rf_raddr2;
  logic [N-1:0]    imm;
  logic [1:0]      alu_func;

  logic [IW-1:0]   rom [32];
  assign instr = rom[pc];

  always #5 clk = ~clk;

  pico_ctrl_seq #(.N(N), .AW(AW), .PCW(PCW), .OPW(OPW)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .sw_ready  (sw_ready),
    .alu_zero  (alu_zero),
    .pc        (pc),
    .rf_write  (rf_write),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .imm       (imm),
    .alu_func  (alu_func),
    .sel_imm   (sel_imm),
    .sel_ext   (sel_ext),
    .halted    (halted)
  );

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           wr;
    logic [AW-1:0]  r1;
    logic [AW-1:0]  r2;
    logic [N-1:0]   imm;
    logic [1:0]     f;
    logic           si;
    logic           se;
    logic           h;
  } obs_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc;
  int    budget;
  string seg;
  bit    sw_sched [64];
  bit    az_sched [64];
  obs_t  tr [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [PCW-1:0] p, input logic w, input logic [IW-1:0] i,
                              input logic [1:0] f, input logic si, input logic se, input logic h);
    obs_t o;
    o.pc = p; o.wr = w; o.r1 = i[RD_MSB:RD_LSB]; o.r2 = i[RS_MSB:RS_LSB];
    o.imm = i[IMM_MSB:IMM_LSB]; o.f = f; o.si = si; o.se = se; o.h = h;
    return o;
  endfunction

  // Compare one cycle, record what the DUT showed, then drive this cycle's inputs.
  task automatic step(input obs_t e);
    string p;
    if (cyc >= budget) return;
    p = $sformatf("%s c%0d", seg, cyc);
    tr[cyc] = '{pc, rf_write, rf_raddr1, rf_raddr2, imm, alu_func, sel_imm, sel_ext, halted};
    check({p, " pc"},       pc,        e.pc);
    check({p, " rf_write"}, rf_write,  e.wr);
    check({p, " raddr1"},   rf_raddr1, e.r1);
    check({p, " raddr2"},   rf_raddr2, e.r2);
    check({p, " imm"},      imm,       e.imm);
    check({p, " alu_func"}, alu_func,  e.f);
    check({p, " sel_imm"},  sel_imm,   e.si);
    check({p, " sel_ext"},  sel_ext,   e.se);
    check({p, " halted"},   halted,    e.h);
    sw_ready = sw_sched[cyc];
    alu_zero = az_sched[cyc];
    cyc++;
    @(negedge clk);
  endtask

  // Instruction-level model: runs the program from pc 0 for ncyc cycles.
  task automatic run_model(input int ncyc);
    logic [PCW-1:0] mpc = '0;
    logic [IW-1:0]  ir  = '0;
    opcode_t        op;
    logic [1:0]     f;
    logic           si;
    budget = ncyc;
    cyc    = 0;
    while (cyc < budget) begin
      step(mk(mpc, 1'b0, ir, 2'b00, 1'b0, 1'b0, 1'b0));
      ir = rom[mpc];
      op = opcode_t'(ir[OP_MSB:OP_LSB]);
      f  = 2'b00;
      si = 1'b0;
      case (op)
        OP_ADD:  f = 2'b01;
        OP_ADDI: begin f = 2'b01; si = 1'b1; end
        OP_MULI: begin f = 2'b10; si = 1'b1; end
        default: ;
      endcase
      step(mk(mpc, 1'b0, ir, f, si, 1'b0, 1'b0));
      case (op)
        OP_NOP: mpc = mpc + 1'b1;
        OP_JMP: mpc = ir[PCW-1:0];
        OP_BEQ: mpc = alu_zero ? ir[PCW-1:0] : mpc + 1'b1;
        OP_ADD, OP_ADDI, OP_MULI: begin
          step(mk(mpc, 1'b1, ir, f, si, 1'b0, 1'b0));
          mpc = mpc + 1'b1;
        end
        OP_LDSW: begin
          do step(mk(mpc, 1'b0, ir, 2'b00, 1'b0, 1'b1, 1'b0));
          while (!sw_ready && cyc < budget);
          step(mk(mpc, 1'b1, ir, 2'b00, 1'b0, 1'b1, 1'b0));
          mpc = mpc + 1'b1;
          do step(mk(mpc, 1'b0, ir, 2'b00, 1'b0, 1'b1, 1'b0));
          while (sw_ready && cyc < budget);
        end
        OP_HLT: while (cyc < budget) step(mk(mpc, 1'b0, ir, 2'b00, 1'b0, 1'b0, 1'b1));
        default: ;
      endcase
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset    = 1'b0;
    sw_ready = 1'b0;
    alu_zero = 1'b0;
  endtask

  task automatic clear_setup();
    for (int i = 0; i < 32; i++) rom[i] = make_instr(OP_NOP, 2'd0, 2'd0, 8'd0);
    for (int i = 0; i < 64; i++) begin
      sw_sched[i] = 1'b0;
      az_sched[i] = 1'b0;
    end
  endtask

  initial begin
    int nw;

    // Segment A: ADDI, two LDSW handshakes, BEQ taken/not taken, JMP 0xFF, HLT
    seg = "A";
    clear_setup();
    rom[0]  = make_instr(OP_ADDI, 2'd1, 2'd0, 8'd5);
    rom[1]  = make_instr(OP_LDSW, 2'd2, 2'd0, 8'd0);
    rom[2]  = make_instr(OP_LDSW, 2'd3, 2'd0, 8'd0);
    rom[3]  = make_instr(OP_BEQ,  2'd0, 2'd0, 8'd7);
    rom[7]  = make_instr(OP_BEQ,  2'd1, 2'd2, 8'd7);
    rom[8]  = make_instr(OP_JMP,  2'd0, 2'd0, 8'hFF);
    rom[31] = make_instr(OP_HLT,  2'd0, 2'd0, 8'd0);
    sw_sched[9] = 1'b1; sw_sched[10] = 1'b1;
    for (int i = 12; i < 18; i++) sw_sched[i] = 1'b1;
    az_sched[20] = 1'b1;
    do_reset(3);
    check("A reset pc", pc, 0);
    check("A reset rf_write", rf_write, 0);
    check("A reset halted", halted, 0);
    run_model(50);
    check("A addi raddr1", tr[1].r1, 1);
    check("A addi func", tr[1].f, 2'b01);
    check("A addi sel_imm", tr[1].si, 1);
    check("A addi imm", tr[1].imm, 5);
    check("A addi wb write", tr[2].wr, 1);
    check("A addi pc@3", tr[3].pc, 1);
    nw = 0;
    for (int k = 3; k < 12; k++) nw += int'(tr[k].wr);
    check("A ldsw single write", nw, 1);
    check("A ldsw wb cycle", tr[10].wr, 1);
    check("A ldsw raddr1", tr[10].r1, 2);
    check("A ldsw sel_ext wait", tr[7].se, 1);
    check("A ldsw pc after fall", tr[12].pc, 2);
    check("A ldsw fast wb", tr[15].wr, 1);
    check("A ldsw2 pc", tr[19].pc, 3);
    check("A beq taken pc", tr[21].pc, 7);
    check("A beq not taken pc", tr[23].pc, 8);
    check("A jmp ff pc", tr[25].pc, 31);
    check("A halted set", tr[27].h, 1);
    check("A halt pc frozen", tr[49].pc, 31);

    // Segment B: MULI, ADD wrapping 31 -> 0, HLT then reset
    seg = "B";
    clear_setup();
    rom[0]  = make_instr(OP_BEQ,  2'd0, 2'd0, 8'd20);
    rom[1]  = make_instr(OP_JMP,  2'd0, 2'd0, 8'd30);
    rom[30] = make_instr(OP_MULI, 2'd2, 2'd2, 8'd3);
    rom[31] = make_instr(OP_ADD,  2'd1, 2'd2, 8'd0);
    rom[20] = make_instr(OP_HLT,  2'd0, 2'd0, 8'd0);
    az_sched[11] = 1'b1;
    do_reset(2);
    check("B reset from halt pc", pc, 0);
    check("B reset from halt halted", halted, 0);
    run_model(40);
    check("B muli func", tr[5].f, 2'b10);
    check("B muli sel_imm", tr[5].si, 1);
    check("B add func", tr[8].f, 2'b01);
    check("B add sel_imm", tr[8].si, 0);
    check("B wrap pc", tr[10].pc, 0);
    check("B beq to halt pc", tr[12].pc, 20);
    check("B halted", tr[14].h, 1);
    check("B halt pc held", tr[39].pc, 20);
    nw = 0;
    for (int k = 13; k < 40; k++) nw += int'(tr[k].wr);
    check("B no write in halt", nw, 0);

    // Segment C: reset held mid-handshake in WAIT_HI, then a clean LDSW
    seg = "C";
    clear_setup();
    rom[0] = make_instr(OP_LDSW, 2'd2, 2'd1, 8'd0);
    do_reset(1);
    run_model(6);
    check("C in wait_hi", sel_ext, 1);
    sw_ready = 1'b1;
    do_reset(3);
    check("C reset pc", pc, 0);
    check("C reset rf_write", rf_write, 0);
    check("C reset halted", halted, 0);
    check("C reset sel_ext", sel_ext, 0);
    sw_sched[4] = 1'b1;
    run_model(12);
    check("C ldsw wb", tr[5].wr, 1);
    check("C next fetch pc", tr[7].pc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
